// File: rtl/rbcp_router_pkg.sv
// rtl/rbcp_router_pkg.sv - shared types and helpers for the RBCP-to-Wishbone router
// Purpose : transaction state encoding, fault read value and index-width helper.
// Ports   : none (package).
package rbcp_router_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    BUS    = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Read data returned on error, timeout or unmapped access.
  localparam logic [7:0] RD_FAULT = 8'h00;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rbcp_wb_router_if.sv
// rtl/rbcp_wb_router_if.sv - RBCP request side and Wishbone slave side of the router
// Purpose : bundles the RBCP handshake and the shared Wishbone bus.
// Ports   : master = router view (drives o_* signals), slave = environment view
//           (drives RBCP requests and slave responses i_*).
interface rbcp_wb_router_if #(
  parameter int NUM_SLV = 16
);
  logic                 i_rbcp_act;
  logic [31:0]          i_rbcp_addr;
  logic                 i_rbcp_we;
  logic [7:0]           i_rbcp_wd;
  logic                 i_rbcp_re;
  logic [7:0]           o_rbcp_rd;
  logic                 o_rbcp_ack;
  logic [15:0]          o_wb_adr;
  logic [7:0]           o_wb_dat;
  logic                 o_wb_we;
  logic                 o_wb_cyc;
  logic [NUM_SLV-1:0]   o_wb_stb;
  logic [NUM_SLV*8-1:0] i_wb_dat;
  logic [NUM_SLV-1:0]   i_wb_ack;
  logic [NUM_SLV-1:0]   i_wb_err;
  logic                 o_timeout;
  logic                 o_bus_err;

  modport master (
    input  i_rbcp_act, i_rbcp_addr, i_rbcp_we, i_rbcp_wd, i_rbcp_re,
    input  i_wb_dat, i_wb_ack, i_wb_err,
    output o_rbcp_rd, o_rbcp_ack, o_wb_adr, o_wb_dat, o_wb_we, o_wb_cyc, o_wb_stb,
    output o_timeout, o_bus_err
  );

  modport slave (
    output i_rbcp_act, i_rbcp_addr, i_rbcp_we, i_rbcp_wd, i_rbcp_re,
    output i_wb_dat, i_wb_ack, i_wb_err,
    input  o_rbcp_rd, o_rbcp_ack, o_wb_adr, o_wb_dat, o_wb_we, o_wb_cyc, o_wb_stb,
    input  o_timeout, o_bus_err
  );
endinterface

// File: rtl/rbcp_router_decode.sv
// rtl/rbcp_router_decode.sv - combinational RBCP address to slave decoder
// Purpose : region = addr[31:16]; sub-selected regions take ch = addr[15:8] and an
//           8-bit Wishbone offset, others use ch 0 and the full 16-bit offset.
// Ports   : addr (in, 32), valid (out), idx (out, slave index), wb_adr (out, 16).
module rbcp_router_decode import rbcp_router_pkg::*; #(
  parameter int                    NUM_REGION    = 4,
  parameter int                    CH_PER_REGION = 4,
  parameter logic [NUM_REGION-1:0] SUBSEL_MASK   = 4'b1110,
  parameter int                    IDX_W         = idx_width(NUM_REGION * CH_PER_REGION)
) (
  input  logic [31:0]      addr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [15:0]      wb_adr
);

  logic [15:0] region;
  logic [7:0]  ch;
  logic        subsel;

  always_comb begin
    region = addr[31:16];
    subsel = 1'b0;
    // Out-of-range regions keep subsel 0; they are rejected by valid anyway.
    for (int r = 0; r < NUM_REGION; r++) begin
      if (region == 16'(r)) subsel = SUBSEL_MASK[r];
    end
    ch     = subsel ? addr[15:8] : 8'h00;
    wb_adr = subsel ? {8'h00, addr[7:0]} : addr[15:0];
    valid  = ({16'h0000, region} < 32'(NUM_REGION)) &&
             ({24'h000000, ch} < 32'(CH_PER_REGION));
    idx    = IDX_W'({16'h0000, region} * 32'(CH_PER_REGION) + {24'h000000, ch});
  end

endmodule

// File: rtl/rbcp_wb_router.sv
// rtl/rbcp_wb_router.sv - RBCP-to-Wishbone bridge routing to NUM_REGION x CH_PER_REGION slaves
// Purpose : one single-beat Wishbone transaction per RBCP strobe with timeout, slave
//           ERR, unmapped completion and abort when i_rbcp_act drops.
// Ports   : i_clk, i_rst_n (async active-low), rif (rbcp_wb_router_if.master).
//           RBCP_ROUTER_STATS_EN adds o_txn_cnt[31:0], o_timeout_cnt[15:0], o_err_cnt[15:0].
module rbcp_wb_router import rbcp_router_pkg::*; #(
  parameter int                    NUM_REGION    = 4,
  parameter int                    CH_PER_REGION = 4,
  parameter logic [NUM_REGION-1:0] SUBSEL_MASK   = 4'b1110,
  parameter int                    TIMEOUT       = 255
) (
  input logic              i_clk,
  input logic              i_rst_n,
  rbcp_wb_router_if.master rif
`ifdef RBCP_ROUTER_STATS_EN
  ,
  output logic [31:0]      o_txn_cnt,
  output logic [15:0]      o_timeout_cnt,
  output logic [15:0]      o_err_cnt
`endif
);

  localparam int NUM_SLV = NUM_REGION * CH_PER_REGION;
  localparam int IDX_W   = idx_width(NUM_SLV);
  localparam int CNT_W   = idx_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [7:0]         wd_q, wd_d;
  logic [15:0]        adr_q, adr_d;
  logic               wbwe_q, wbwe_d;
  logic               cyc_q, cyc_d;
  logic [NUM_SLV-1:0] stb_q, stb_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         cap_q, cap_d;
  logic               err_q, err_d, to_q, to_d;
  logic               ack_q, ack_d;
  logic [7:0]         rd_q, rd_d;
  logic               bus_err_q, bus_err_d, timeout_q, timeout_d;

  logic               dec_valid;
  logic [IDX_W-1:0]   dec_idx;
  logic [15:0]        dec_adr;
  logic               ack_hit, err_hit;
  logic [7:0]         slv_dat;

  rbcp_router_decode #(
    .NUM_REGION   (NUM_REGION),
    .CH_PER_REGION(CH_PER_REGION),
    .SUBSEL_MASK  (SUBSEL_MASK),
    .IDX_W        (IDX_W)
  ) u_decode (
    .addr  (addr_q),
    .valid (dec_valid),
    .idx   (dec_idx),
    .wb_adr(dec_adr)
  );

  // Strobe is one-hot, so masking with it observes only the selected slave.
  assign ack_hit = |(rif.i_wb_ack & stb_q);
  assign err_hit = |(rif.i_wb_err & stb_q);
  assign slv_dat = rif.i_wb_dat[{idx_q, 3'b000} +: 8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      adr_q     <= '0;
      wbwe_q    <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      ack_q     <= 1'b0;
      rd_q      <= '0;
      bus_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wd_q      <= wd_d;
      adr_q     <= adr_d;
      wbwe_q    <= wbwe_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      err_q     <= err_d;
      to_q      <= to_d;
      ack_q     <= ack_d;
      rd_q      <= rd_d;
      bus_err_q <= bus_err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wd_d      = wd_q;
    adr_d     = adr_q;
    wbwe_d    = wbwe_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    err_d     = err_q;
    to_d      = to_q;
    ack_d     = 1'b0;
    rd_d      = 8'h00;
    bus_err_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rif.i_rbcp_act && (rif.i_rbcp_we || rif.i_rbcp_re)) begin
          addr_d  = rif.i_rbcp_addr;
          we_d    = rif.i_rbcp_we;
          wd_d    = rif.i_rbcp_we ? rif.i_rbcp_wd : 8'h00;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!rif.i_rbcp_act) begin
          state_d = IDLE;
        end else if (!dec_valid) begin
          cap_d   = RD_FAULT;
          err_d   = 1'b1;
          to_d    = 1'b0;
          state_d = RESP;
        end else begin
          idx_d   = dec_idx;
          adr_d   = dec_adr;
          stb_d   = NUM_SLV'(1) << dec_idx;
          cyc_d   = 1'b1;
          wbwe_d  = we_q;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Every exit drops the bus; only the wait path keeps it driven.
        cyc_d  = 1'b0;
        stb_d  = '0;
        wbwe_d = 1'b0;
        if (!rif.i_rbcp_act) begin
          state_d = IDLE;
        end else if (err_hit) begin
          cap_d   = RD_FAULT;
          err_d   = 1'b1;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (ack_hit) begin
          cap_d   = we_q ? 8'h00 : slv_dat;
          err_d   = 1'b0;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cap_d   = RD_FAULT;
          err_d   = 1'b0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cyc_d  = 1'b1;
          stb_d  = stb_q;
          wbwe_d = wbwe_q;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        ack_d     = 1'b1;
        rd_d      = cap_q;
        bus_err_d = err_q;
        timeout_d = to_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rif.o_rbcp_ack = ack_q;
  assign rif.o_rbcp_rd  = rd_q;
  assign rif.o_wb_adr   = adr_q;
  assign rif.o_wb_dat   = wd_q;
  assign rif.o_wb_we    = wbwe_q;
  assign rif.o_wb_cyc   = cyc_q;
  assign rif.o_wb_stb   = stb_q;
  assign rif.o_timeout  = timeout_q;
  assign rif.o_bus_err  = bus_err_q;

`ifdef RBCP_ROUTER_STATS_EN
  logic [31:0] txn_cnt_q;
  logic [15:0] to_cnt_q, err_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      txn_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (txn_cnt_q != '1)         txn_cnt_q <= txn_cnt_q + 32'd1;
      if (to_q && to_cnt_q != '1)   to_cnt_q  <= to_cnt_q + 16'd1;
      if (err_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign o_txn_cnt     = txn_cnt_q;
  assign o_timeout_cnt = to_cnt_q;
  assign o_err_cnt     = err_cnt_q;
`endif

endmodule

// File: tb/tb_rbcp_wb_router.sv
// tb/tb_rbcp_wb_router.sv - scoreboard bench for rbcp_wb_router (TIMEOUT=16)
module tb_rbcp_wb_router;

  localparam int NS = 16;

  logic clk;
  logic rst_n;
  int   cyc_cnt;
  int   total;
  int   bad;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    logic       to;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  int         mode[NS];
  int         dly[NS];
  logic [7:0] sdat[NS];
  int         scnt[NS];
  int         run_len;
  int         last_run;
  int         exp_txn;
  int         exp_to_n;
  int         exp_err_n;

  rbcp_wb_router_if #(.NUM_SLV(NS)) rif ();

`ifdef RBCP_ROUTER_STATS_EN
  logic [31:0] txn_cnt;
  logic [15:0] timeout_cnt;
  logic [15:0] err_cnt;
`endif

  rbcp_wb_router #(.TIMEOUT(16)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .rif    (rif)
`ifdef RBCP_ROUTER_STATS_EN
    ,
    .o_txn_cnt    (txn_cnt),
    .o_timeout_cnt(timeout_cnt),
    .o_err_cnt    (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc_cnt = 0;
    forever begin
      @(posedge clk);
      cyc_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc_cnt);
    end
  endtask

  // Slave models: 0 silent, 1 ack, 2 err, 3 ack+err, 4 ack always (noise).
  initial begin
    logic [NS-1:0]   a;
    logic [NS-1:0]   e;
    logic [NS*8-1:0] d;
    rif.i_wb_ack = '0;
    rif.i_wb_err = '0;
    rif.i_wb_dat = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NS; k++) begin
        if (rif.o_wb_stb[k] === 1'b1) scnt[k]++;
        else scnt[k] = 0;
        a[k] = (((mode[k] == 1) || (mode[k] == 3)) && (scnt[k] > dly[k])) || (mode[k] == 4);
        e[k] = ((mode[k] == 2) || (mode[k] == 3)) && (scnt[k] > dly[k]);
        d[k*8 +: 8] = sdat[k];
      end
      rif.i_wb_ack = a;
      rif.i_wb_err = e;
      rif.i_wb_dat = d;
    end
  end

  // Response monitor: pops one expectation per acknowledge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rif.o_rbcp_ack === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack rd=%0h cycle=%0d", rif.o_rbcp_rd, cyc_cnt);
        end else begin
          x = sb_q.pop_front();
          chk("ack_rd", 32'(rif.o_rbcp_rd), 32'(x.rd));
          chk("ack_bus_err", 32'(rif.o_bus_err), 32'(x.err));
          chk("ack_timeout", 32'(rif.o_timeout), 32'(x.to));
          chk("ack_cycle", cyc_cnt, x.cyc);
        end
      end else if ((rif.o_timeout === 1'b1) || (rif.o_bus_err === 1'b1)) begin
        total++;
        bad++;
        $display("FAIL stray_pulse timeout=%0b bus_err=%0b exp=0", rif.o_timeout, rif.o_bus_err);
      end
    end
  end

  // Length of the most recent Wishbone cycle, in clocks.
  initial begin
    run_len = 0;
    last_run = 0;
    forever begin
      @(negedge clk);
      if (rif.o_wb_cyc === 1'b1) run_len++;
      else if (run_len != 0) begin
        last_run = run_len;
        run_len = 0;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d exp=0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic txn(input bit is_we, input logic [31:0] addr, input logic [7:0] wd,
                     input bit mapped, input int slv, input logic [15:0] exp_adr,
                     input logic [7:0] exp_rd, input bit exp_err, input bit exp_to,
                     input int lat, input bit extra);
    exp_t e;
    @(negedge clk);
    rif.i_rbcp_addr = addr;
    rif.i_rbcp_wd   = wd;
    rif.i_rbcp_we   = is_we;
    rif.i_rbcp_re   = !is_we;
    e.rd  = exp_rd;
    e.err = exp_err;
    e.to  = exp_to;
    e.cyc = cyc_cnt + lat;
    sb_q.push_back(e);
    exp_txn++;
    if (exp_to) exp_to_n++;
    if (exp_err) exp_err_n++;
    @(negedge clk);
    rif.i_rbcp_we = 1'b0;
    rif.i_rbcp_re = 1'b0;
    @(negedge clk);
    if (mapped) begin
      chk("bus_cyc", 32'(rif.o_wb_cyc), 32'd1);
      chk("bus_stb", 32'(rif.o_wb_stb), 32'(1) << slv);
      chk("bus_adr", 32'(rif.o_wb_adr), 32'(exp_adr));
      chk("bus_we", 32'(rif.o_wb_we), 32'(is_we));
      if (is_we) chk("bus_dat", 32'(rif.o_wb_dat), 32'(wd));
    end else begin
      chk("unmapped_cyc", 32'(rif.o_wb_cyc), 32'd0);
      chk("unmapped_stb", 32'(rif.o_wb_stb), 32'd0);
    end
    if (extra) begin
      @(negedge clk);
      rif.i_rbcp_re = 1'b1;
      @(negedge clk);
      rif.i_rbcp_re = 1'b0;
    end
    drain("txn_done");
  endtask

  task automatic chk_stats();
`ifdef RBCP_ROUTER_STATS_EN
    chk("txn_cnt", txn_cnt, 32'(exp_txn));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(exp_to_n));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err_n));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    exp_txn = 0;
    exp_to_n = 0;
    exp_err_n = 0;
    for (int k = 0; k < NS; k++) begin
      mode[k] = 0;
      dly[k]  = 0;
      sdat[k] = 8'(k * 17);
      scnt[k] = 0;
    end
    rst_n = 1'b0;
    rif.i_rbcp_act  = 1'b0;
    rif.i_rbcp_addr = '0;
    rif.i_rbcp_we   = 1'b0;
    rif.i_rbcp_wd   = '0;
    rif.i_rbcp_re   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack", 32'(rif.o_rbcp_ack), 32'd0);
    chk("rst_rd", 32'(rif.o_rbcp_rd), 32'd0);
    chk("rst_cyc", 32'(rif.o_wb_cyc), 32'd0);
    chk("rst_stb", 32'(rif.o_wb_stb), 32'd0);
    chk("rst_adr", 32'(rif.o_wb_adr), 32'd0);
    chk("rst_dat", 32'(rif.o_wb_dat), 32'd0);
    chk("rst_we", 32'(rif.o_wb_we), 32'd0);
    chk("rst_timeout", 32'(rif.o_timeout), 32'd0);
    chk("rst_bus_err", 32'(rif.o_bus_err), 32'd0);
    chk_stats();

    rif.i_rbcp_act = 1'b1;

    // Region 0 has no sub-select: slave 0, full 16-bit offset.
    mode[0] = 1; dly[0] = 0; sdat[0] = 8'hA5;
    txn(1'b0, 32'h0000_0012, 8'h00, 1'b1, 0, 16'h0012, 8'hA5, 1'b0, 1'b0, 4, 1'b0);
    txn(1'b0, 32'h0000_FF34, 8'h00, 1'b1, 0, 16'hFF34, 8'hA5, 1'b0, 1'b0, 4, 1'b0);

    // Write to region 2 ch 1 (slave 9), late ack, extra strobe while busy.
    mode[9] = 1; dly[9] = 2; sdat[9] = 8'h99;
    txn(1'b1, 32'h0002_0103, 8'h5C, 1'b1, 9, 16'h0003, 8'h00, 1'b0, 1'b0, 6, 1'b1);

    // Last slave: region 3 ch 3.
    mode[15] = 1; dly[15] = 1; sdat[15] = 8'h3C;
    txn(1'b0, 32'h0003_0302, 8'h00, 1'b1, 15, 16'h0002, 8'h3C, 1'b0, 1'b0, 5, 1'b0);

    // Silent slave 0 times out; noisy slave 5 must be ignored.
    mode[0] = 0; mode[5] = 4;
    last_run = 0;
    txn(1'b0, 32'h0000_0020, 8'h00, 1'b1, 0, 16'h0020, 8'h00, 1'b0, 1'b1, 19, 1'b0);
    chk("stb_high_cycles", last_run, 16);
    mode[5] = 0;

    // Abort: drop act while the bus cycle is waiting.
    @(negedge clk);
    rif.i_rbcp_addr = 32'h0000_0040;
    rif.i_rbcp_re = 1'b1;
    @(negedge clk);
    rif.i_rbcp_re = 1'b0;
    @(negedge clk);
    chk("abort_cyc_before", 32'(rif.o_wb_cyc), 32'd1);
    @(negedge clk);
    rif.i_rbcp_act = 1'b0;
    @(negedge clk);
    chk("abort_cyc_after", 32'(rif.o_wb_cyc), 32'd0);
    chk("abort_stb_after", 32'(rif.o_wb_stb), 32'd0);
    repeat (6) @(negedge clk);
    rif.i_rbcp_act = 1'b1;

    mode[6] = 1; dly[6] = 0; sdat[6] = 8'h66;
    txn(1'b0, 32'h0001_0200, 8'h00, 1'b1, 6, 16'h0000, 8'h66, 1'b0, 1'b0, 4, 1'b0);

    // ACK and ERR together: error takes priority.
    mode[10] = 3; dly[10] = 0; sdat[10] = 8'hAA;
    txn(1'b0, 32'h0002_0200, 8'h00, 1'b1, 10, 16'h0000, 8'h00, 1'b1, 1'b0, 4, 1'b0);
    chk_stats();

    // Unmapped region and channel beyond CH_PER_REGION.
    txn(1'b0, 32'h0007_0000, 8'h00, 1'b0, 0, 16'h0000, 8'h00, 1'b1, 1'b0, 3, 1'b0);
    txn(1'b0, 32'h0001_0400, 8'h00, 1'b0, 0, 16'h0000, 8'h00, 1'b1, 1'b0, 3, 1'b0);

    // ERR only, on a write to region 3 ch 1 (slave 13).
    mode[13] = 2; dly[13] = 0; sdat[13] = 8'hD3;
    txn(1'b1, 32'h0003_0155, 8'h77, 1'b1, 13, 16'h0055, 8'h00, 1'b1, 1'b0, 4, 1'b0);
    chk_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
